// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit, common-anode 7-segment scanner with dead time between digits.
// The display register is loaded by a strobe; the outputs are registered and only change at digit boundaries.
module seg7_scan #(
    parameter int DIGIT_TICKS = 50000,
    parameter int DEAD_TICKS  = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int MAX_TICKS = (DIGIT_TICKS > DEAD_TICKS) ? DIGIT_TICKS : DEAD_TICKS;
    localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_TICKS - 1);

    typedef enum logic {DEAD, DRIVE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [15:0] disp_value_reg;
    logic [3:0]  disp_blank_reg;
    logic [3:0]  disp_dp_reg;

    logic [6:0]  seg_reg, seg_next;
    logic        dp_n_reg, dp_n_next;
    logic [3:0]  an_reg, an_next;
    logic        frame_done_reg, frame_done_next;

    logic [3:0]  nib [4];
    logic [3:0]  an_sel;
    logic [3:0]  cur_nib;
    logic [6:0]  cur_seg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign nib[gi]    = disp_value_reg[4*gi+3:4*gi];
            assign an_sel[gi] = (idx_next != 2'(gi));
        end
    endgenerate

    assign cur_nib = nib[idx_next];

    always_comb begin
        cur_seg = 7'h7F;
        case (cur_nib)
            4'h0: cur_seg = 7'h40;
            4'h1: cur_seg = 7'h79;
            4'h2: cur_seg = 7'h24;
            4'h3: cur_seg = 7'h30;
            4'h4: cur_seg = 7'h19;
            4'h5: cur_seg = 7'h12;
            4'h6: cur_seg = 7'h02;
            4'h7: cur_seg = 7'h78;
            4'h8: cur_seg = 7'h00;
            4'h9: cur_seg = 7'h10;
            4'hA: cur_seg = 7'h08;
            4'hB: cur_seg = 7'h03;
            4'hC: cur_seg = 7'h46;
            4'hD: cur_seg = 7'h21;
            4'hE: cur_seg = 7'h06;
            4'hF: cur_seg = 7'h0E;
            default: cur_seg = 7'h7F;
        endcase
    end

    // Next-state and output register loads; outputs only move on phase boundaries.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg + 1'b1;
        seg_next        = seg_reg;
        dp_n_next       = dp_n_reg;
        an_next         = an_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            DEAD: begin
                if (cnt_reg == DEAD_LAST) begin
                    state_next = DRIVE;
                    idx_next   = idx_reg + 2'd1;
                    cnt_next   = '0;
                    if (disp_blank_reg[idx_next]) begin
                        seg_next  = 7'h7F;
                        dp_n_next = 1'b1;
                        an_next   = 4'hF;
                    end else begin
                        seg_next  = cur_seg;
                        dp_n_next = ~disp_dp_reg[idx_next];
                        an_next   = an_sel;
                    end
                end
            end
            DRIVE: begin
                if (cnt_reg == DIGIT_LAST) begin
                    state_next      = DEAD;
                    cnt_next        = '0;
                    seg_next        = 7'h7F;
                    dp_n_next       = 1'b1;
                    an_next         = 4'hF;
                    frame_done_next = (idx_reg == 2'd3);
                end
            end
            default: begin
                state_next = DEAD;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= DEAD;
            idx_reg        <= 2'd3;
            cnt_reg        <= '0;
            disp_value_reg <= 16'h0000;
            disp_blank_reg <= 4'hF;
            disp_dp_reg    <= 4'h0;
            seg_reg        <= 7'h7F;
            dp_n_reg       <= 1'b1;
            an_reg         <= 4'hF;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            seg_reg        <= seg_next;
            dp_n_reg       <= dp_n_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_done_next;
            if (load) begin
                disp_value_reg <= value;
                disp_blank_reg <= blank;
                disp_dp_reg    <= dp;
            end
        end
    end

    assign seg        = seg_reg;
    assign dp_n       = dp_n_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule
